// File: rtl/masked_sbox_scheduler.sv
// masked_sbox_scheduler: issues at most one shared byte per cycle from
// NUM_REQ requesters into a LATENCY-deep masked GF(2^8) inverter, tracks
// the in-flight tokens and routes each result back to its requester.
// It also asks the PRNG to advance only while masked data is in flight.
// Build option: define MASKED_SBOX_SCHED_RR_EN for round-robin arbitration;
// left undefined, the lowest requester index wins.
// Ports:
//   in_clock, in_reset   clock, asynchronous active-high reset
//   in_req_valid/data    per-requester request and shared input byte
//   out_req_ready        one-hot grant (accept = valid & ready)
//   out_inv_a, in_inv_b  inverter input / output shares
//   in_rand_valid        PRNG output fresh this cycle
//   out_rand_req         PRNG advance request
//   out_rsp_valid/data   one-hot response strobe and response byte
//   in_flush             synchronous abort of all in-flight tokens
//   out_busy             at least one token in flight
//   out_rand_error       sticky randomness-underrun flag
module masked_sbox_scheduler #(
   parameter int NUM_SHARES = 2,
   parameter int LATENCY    = 4,
   parameter int NUM_REQ    = 2
) (
   input  logic                            in_clock,
   input  logic                            in_reset,
   input  logic [NUM_REQ-1:0]              in_req_valid,
   input  logic [NUM_REQ*NUM_SHARES*8-1:0] in_req_data,
   output logic [NUM_REQ-1:0]              out_req_ready,
   output logic [NUM_SHARES*8-1:0]         out_inv_a,
   input  logic [NUM_SHARES*8-1:0]         in_inv_b,
   input  logic                            in_rand_valid,
   output logic                            out_rand_req,
   output logic [NUM_REQ-1:0]              out_rsp_valid,
   output logic [NUM_SHARES*8-1:0]         out_rsp_data,
   input  logic                            in_flush,
   output logic                            out_busy,
   output logic                            out_rand_error
);

   localparam int SW  = NUM_SHARES * 8;
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW  = $clog2(LATENCY + 1);
   localparam int NP  = 1 << IDW;

   logic [LATENCY-1:0] tok_v;
   logic [IDW-1:0]     tok_id [LATENCY];
   logic [CW-1:0]      count;
   logic [NP-1:0]      req_pad;
   logic [IDW-1:0]     win;
   logic [IDW-1:0]     cand;
   logic               found;
   logic               issue;
   logic               retire;

   // Padding lets the candidate index address the vector at its own width.
   assign req_pad = NP'(in_req_valid);

`ifdef MASKED_SBOX_SCHED_RR_EN
   logic [IDW-1:0] ptr;

   // Search starts at the pointer and wraps around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDW'((int'(ptr) + i) % NUM_REQ);
         if (!found && req_pad[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         ptr <= '0;
      end else if (issue) begin
         ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      end
   end
`else
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDW'(i);
         if (!found && req_pad[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end
`endif

   // Reset gating keeps every output at zero while reset is held.
   assign issue = found & in_rand_valid & ~in_flush & ~in_reset;

   assign out_req_ready = issue ? (NUM_REQ'(1) << win) : '0;

   // Idle cycles drive zero shares so no stale masked value is replayed.
   assign out_inv_a = issue ? in_req_data[int'(win)*SW +: SW] : '0;

   // A flush in the retire cycle drops that response.
   assign retire = tok_v[LATENCY-1] & ~in_flush;

   assign out_rsp_valid = retire ? (NUM_REQ'(1) << tok_id[LATENCY-1]) : '0;
   assign out_rsp_data  = retire ? in_inv_b : '0;

   assign out_busy     = (count != '0);
   assign out_rand_req = issue | out_busy;

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         tok_v <= '0;
         count <= '0;
      end else if (in_flush) begin
         tok_v <= '0;
         count <= '0;
      end else begin
         tok_v <= {tok_v[LATENCY-2:0], issue};
         if (issue && !tok_v[LATENCY-1] && count != CW'(LATENCY)) begin
            count <= count + 1'b1;
         end else if (!issue && tok_v[LATENCY-1] && count != '0) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            tok_id[i] <= '0;
         end
      end else begin
         tok_id[0] <= issue ? win : '0;
         for (int i = 1; i < LATENCY; i++) begin
            tok_id[i] <= tok_id[i-1];
         end
      end
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         out_rand_error <= 1'b0;
      end else if (out_busy && !in_rand_valid) begin
         out_rand_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// tb_masked_sbox_scheduler: randomized bench for masked_sbox_scheduler
// with a pipelined masked-inverter model and a queue-based reference.
module tb_masked_sbox_scheduler;

   localparam int L = 4;

   logic        in_clock = 1'b0;
   logic        in_reset = 1'b1;
   logic [1:0]  in_req_valid = '0;
   logic [31:0] in_req_data = '0;
   logic [1:0]  out_req_ready;
   logic [15:0] out_inv_a;
   logic [15:0] in_inv_b;
   logic        in_rand_valid = 1'b0;
   logic        out_rand_req;
   logic [1:0]  out_rsp_valid;
   logic [15:0] out_rsp_data;
   logic        in_flush = 1'b0;
   logic        out_busy;
   logic        out_rand_error;

   masked_sbox_scheduler #(
      .NUM_SHARES(2),
      .LATENCY(L),
      .NUM_REQ(2)
   ) dut (
      .in_clock(in_clock),
      .in_reset(in_reset),
      .in_req_valid(in_req_valid),
      .in_req_data(in_req_data),
      .out_req_ready(out_req_ready),
      .out_inv_a(out_inv_a),
      .in_inv_b(in_inv_b),
      .in_rand_valid(in_rand_valid),
      .out_rand_req(out_rand_req),
      .out_rsp_valid(out_rsp_valid),
      .out_rsp_data(out_rsp_data),
      .in_flush(in_flush),
      .out_busy(out_busy),
      .out_rand_error(out_rand_error)
   );

   always #5 in_clock = ~in_clock;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge in_clock) cyc <= cyc + 1;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      if (a == 8'h00) return 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (gf_mul(a, 8'(y)) == 8'h01) return 8'(y);
      end
      return 8'h00;
   endfunction

   function automatic logic [7:0] unmask(input logic [15:0] s);
      return s[15:8] ^ s[7:0];
   endfunction

   function automatic logic [15:0] remask(input logic [7:0] v, input logic [7:0] m);
      return {v ^ m, m};
   endfunction

   // Masked inverter: L register stages, fresh output mask each cycle.
   logic [15:0] pipe [L];
   always @(posedge in_clock) begin
      pipe[0] <= remask(gf_inv(unmask(out_inv_a)), 8'($urandom));
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign in_inv_b = pipe[L-1];

   // Reference: outstanding results as {due cycle, requester, value}.
   typedef struct {
      int         due;
      int         id;
      logic [7:0] val;
   } exp_t;

   exp_t q[$];
   int   mdl_ptr = 0;
   bit   err_m   = 0;

   logic [1:0] e_ready;
   logic [7:0] e_a;
   logic [1:0] e_rsp_v;
   logic [7:0] e_rsp;
   bit         e_busy;
   bit         e_rreq;
   bit         e_err;
   int         e_inflight;

   function automatic int ref_grant(input logic [1:0] v, input bit rv, input bit fl);
      if (!rv || fl || v == 2'b00) return -1;
`ifdef MASKED_SBOX_SCHED_RR_EN
      for (int i = 0; i < 2; i++) begin
         if (v[(mdl_ptr + i) % 2]) return (mdl_ptr + i) % 2;
      end
`else
      for (int r = 0; r < 2; r++) begin
         if (v[r]) return r;
      end
`endif
      return -1;
   endfunction

   // Idle inverter input must be all-zero shares; otherwise compare unmasked.
   function automatic logic [15:0] obs_a();
      return (e_ready == 2'b00) ? out_inv_a : {8'h00, unmask(out_inv_a)};
   endfunction

   function automatic logic [15:0] obs_rsp();
      return (e_rsp_v == 2'b00) ? out_rsp_data : {8'h00, unmask(out_rsp_data)};
   endfunction

   // Drives one cycle of inputs and advances the reference model.
   task automatic drive_cycle(input logic [1:0] v, input logic [7:0] p0,
                              input logic [7:0] p1, input bit rv, input bit fl);
      int g;
      logic [7:0] m0;
      logic [7:0] m1;
      @(negedge in_clock);
      m0 = 8'($urandom);
      m1 = 8'($urandom);
      in_req_valid  = v;
      in_req_data   = {p1 ^ m1, m1, p0 ^ m0, m0};
      in_rand_valid = rv;
      in_flush      = fl;
      #1;
      g          = ref_grant(v, rv, fl);
      e_inflight = q.size();
      e_busy     = (e_inflight != 0);
      e_err      = err_m;
      e_ready    = (g < 0) ? 2'b00 : 2'(1 << g);
      e_a        = (g == 0) ? p0 : (g == 1) ? p1 : 8'h00;
      e_rreq     = (g >= 0) || e_busy;
      e_rsp_v    = 2'b00;
      e_rsp      = 8'h00;
      if (q.size() != 0 && q[0].due == cyc) begin
         if (!fl) begin
            e_rsp_v = 2'(1 << q[0].id);
            e_rsp   = q[0].val;
         end
         void'(q.pop_front());
      end
      if (fl) q.delete();
      if (g >= 0) begin
         q.push_back('{cyc + L, g, gf_inv(e_a)});
         mdl_ptr = (g + 1) % 2;
      end
      if (e_busy && !rv) err_m = 1;
   endtask

   task automatic test_reset();
      @(negedge in_clock);
      in_req_valid  = 2'b11;
      in_req_data   = $urandom;
      in_rand_valid = 1'b1;
      #1;
      n_cmp++;
      if (out_req_ready !== 2'b00 || out_inv_a !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_grant: got %b/%h want 00/0000", out_req_ready, out_inv_a);
      end
      n_cmp++;
      if (out_rsp_valid !== 2'b00 || out_rsp_data !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_rsp: got %b/%h want 00/0000", out_rsp_valid, out_rsp_data);
      end
      n_cmp++;
      if ({out_busy, out_rand_req, out_rand_error} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 000", {out_busy, out_rand_req, out_rand_error});
      end
      @(negedge in_clock);
      in_reset     = 1'b0;
      in_req_valid = 2'b00;
   endtask

   task automatic test_single();
      drive_cycle(2'b10, 8'($urandom), 8'h53, 1'b1, 1'b0);
      n_cmp++;
      if (out_req_ready !== 2'b10) begin
         n_bad++;
         $display("FAIL single_grant: got %b want 10", out_req_ready);
      end
      n_cmp++;
      if (unmask(out_inv_a) !== 8'h53) begin
         n_bad++;
         $display("FAIL single_inv_a: got %h want 53", unmask(out_inv_a));
      end
      for (int k = 1; k <= 6; k++) begin
         drive_cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
         n_cmp++;
         if (out_rsp_valid !== e_rsp_v || obs_rsp() !== {8'h00, e_rsp}) begin
            n_bad++;
            $display("FAIL single_rsp k=%0d: got %b/%h want %b/%h",
                     k, out_rsp_valid, obs_rsp(), e_rsp_v, e_rsp);
         end
         if (k == L) begin
            n_cmp++;
            if (out_rsp_valid !== 2'b10 || unmask(out_rsp_data) !== 8'hca) begin
               n_bad++;
               $display("FAIL single_inverse: got %b/%h want 10/ca",
                        out_rsp_valid, unmask(out_rsp_data));
            end
         end
      end
   endtask

   task automatic test_contention();
      int g1;
      g1 = 0;
      for (int i = 0; i < 11; i++) begin
         drive_cycle((i < 6) ? 2'b11 : 2'b00, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
         n_cmp++;
         if (out_req_ready !== e_ready || obs_a() !== {8'h00, e_a}) begin
            n_bad++;
            $display("FAIL contention_grant i=%0d: got %b/%h want %b/%h",
                     i, out_req_ready, obs_a(), e_ready, e_a);
         end
         n_cmp++;
         if (out_rsp_valid !== e_rsp_v || obs_rsp() !== {8'h00, e_rsp}) begin
            n_bad++;
            $display("FAIL contention_rsp i=%0d: got %b/%h want %b/%h",
                     i, out_rsp_valid, obs_rsp(), e_rsp_v, e_rsp);
         end
         if (out_req_ready[1]) g1++;
      end
      n_cmp++;
`ifdef MASKED_SBOX_SCHED_RR_EN
      if (g1 !== 3) begin
         n_bad++;
         $display("FAIL contention_share: got %0d grants to req1 want 3", g1);
      end
`else
      if (g1 !== 0) begin
         n_bad++;
         $display("FAIL contention_share: got %0d grants to req1 want 0", g1);
      end
`endif
   endtask

   task automatic test_rand_gate();
      drive_cycle(2'b11, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      n_cmp++;
      if (out_req_ready !== 2'b00 || out_rand_req !== 1'b0) begin
         n_bad++;
         $display("FAIL gate_idle: got %b/%b want 00/0", out_req_ready, out_rand_req);
      end
      drive_cycle(2'b01, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      drive_cycle(2'b10, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      drive_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (out_rand_req !== e_rreq || out_busy !== e_busy) begin
         n_bad++;
         $display("FAIL gate_busy: got %b/%b want %b/%b",
                  out_rand_req, out_busy, e_rreq, e_busy);
      end
      for (int i = 0; i < 6; i++) begin
         drive_cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
         n_cmp++;
         if (out_rand_error !== e_err || out_rand_error !== 1'b1) begin
            n_bad++;
            $display("FAIL gate_error i=%0d: got %b want 1", i, out_rand_error);
         end
         n_cmp++;
         if (out_rsp_valid !== e_rsp_v || obs_rsp() !== {8'h00, e_rsp}) begin
            n_bad++;
            $display("FAIL gate_rsp i=%0d: got %b/%h want %b/%h",
                     i, out_rsp_valid, obs_rsp(), e_rsp_v, e_rsp);
         end
      end
   endtask

   task automatic test_flush();
      int seen;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      end
      drive_cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (out_rsp_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL flush_pre_rsp: got %b want 00", out_rsp_valid);
      end
      drive_cycle(2'b11, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
      n_cmp++;
      if (out_rsp_valid !== 2'b00 || out_req_ready !== 2'b00) begin
         n_bad++;
         $display("FAIL flush_cycle: got rsp %b grant %b want 00/00",
                  out_rsp_valid, out_req_ready);
      end
      drive_cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (out_busy !== e_busy || out_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_busy: got %b want 0", out_busy);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         drive_cycle((i == 0) ? 2'b01 : 2'b00, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
         n_cmp++;
         if (out_rsp_valid !== e_rsp_v || obs_rsp() !== {8'h00, e_rsp}) begin
            n_bad++;
            $display("FAIL flush_after i=%0d: got %b/%h want %b/%h",
                     i, out_rsp_valid, obs_rsp(), e_rsp_v, e_rsp);
         end
         if (out_rsp_valid != 2'b00) seen++;
      end
      n_cmp++;
      if (seen !== 1) begin
         n_bad++;
         $display("FAIL flush_recover: got %0d responses want 1", seen);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < L; i++) begin
         drive_cycle(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      end
      @(negedge in_clock);
      in_req_valid  = 2'b11;
      in_rand_valid = 1'b1;
      #2;
      in_reset = 1'b1;
      #1;
      q.delete();
      err_m   = 0;
      mdl_ptr = 0;
      n_cmp++;
      if ({out_req_ready, out_rsp_valid} !== 4'b0000 ||
          {out_inv_a, out_rsp_data} !== 32'h0) begin
         n_bad++;
         $display("FAIL areset_data: got %b %b %h %h want zeros",
                  out_req_ready, out_rsp_valid, out_inv_a, out_rsp_data);
      end
      n_cmp++;
      if ({out_busy, out_rand_req, out_rand_error} !== 3'b000) begin
         n_bad++;
         $display("FAIL areset_flags: got %b want 000",
                  {out_busy, out_rand_req, out_rand_error});
      end
      @(negedge in_clock);
      in_reset     = 1'b0;
      in_req_valid = 2'b00;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
         n_cmp++;
         if (out_rsp_valid !== 2'b00 || out_busy !== e_busy) begin
            n_bad++;
            $display("FAIL areset_after i=%0d: got %b/%b want 00/%b",
                     i, out_rsp_valid, out_busy, e_busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      int seen;
      seen = 0;
      for (int i = 0; i < 26; i++) begin
         drive_cycle((i < 20) ? 2'($urandom_range(1, 3)) : 2'b00,
                     8'($urandom), 8'($urandom), 1'b1, 1'b0);
         n_cmp++;
         if (out_req_ready !== e_ready || obs_a() !== {8'h00, e_a}) begin
            n_bad++;
            $display("FAIL b2b_grant i=%0d: got %b/%h want %b/%h",
                     i, out_req_ready, obs_a(), e_ready, e_a);
         end
         n_cmp++;
         if (out_rsp_valid !== e_rsp_v || obs_rsp() !== {8'h00, e_rsp}) begin
            n_bad++;
            $display("FAIL b2b_rsp i=%0d: got %b/%h want %b/%h",
                     i, out_rsp_valid, obs_rsp(), e_rsp_v, e_rsp);
         end
         n_cmp++;
         if (int'(dut.count) !== e_inflight) begin
            n_bad++;
            $display("FAIL b2b_count i=%0d: got %0d want %0d", i, dut.count, e_inflight);
         end
         if (out_rsp_valid != 2'b00) seen++;
      end
      n_cmp++;
      if (seen !== 20) begin
         n_bad++;
         $display("FAIL b2b_total: got %0d responses want 20", seen);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_rand_gate();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/masked_sbox_scheduler.md
# masked_sbox_scheduler

Issue scheduler that time-shares one pipelined masked GF(2^8) inverter between several requesters, such as the state-byte datapath and the key-schedule S-box path. It arbitrates the requests and issues at most one byte per cycle into the inverter. It tracks the in-flight tokens through the fixed-latency pipeline and routes each result back to its originating requester. It also gates the randomness source so the PRNG only advances while masked data is in the pipeline.

## Interface
Parameters:
- NUM_SHARES, 2, number of Boolean shares per byte.
- LATENCY, 4, inverter pipeline depth in cycles; must match the instantiated inverter (3 or 4).
- NUM_REQ, 2, number of requesters, from 2 to 8.

Ports:
- in_clock, input, 1, single clock.
- in_reset, input, 1, asynchronous, active-high reset.
- in_req_valid, input, NUM_REQ, per-requester request valid.
- in_req_data, input, NUM_REQ×NUM_SHARES×8, per-requester shared input byte.
- out_req_ready, output, NUM_REQ, one-hot grant; a request is accepted when valid and ready are both high.
- out_inv_a, output, NUM_SHARES×8, shared byte driven to the inverter input.
- in_inv_b, input, NUM_SHARES×8, shared byte from the inverter output.
- in_rand_valid, input, 1, PRNG output is fresh this cycle.
- out_rand_req, output, 1, request that the PRNG advance this cycle.
- out_rsp_valid, output, NUM_REQ, one-hot response strobe.
- out_rsp_data, output, NUM_SHARES×8, response byte, shared by all requesters.
- in_flush, input, 1, synchronous abort of all in-flight tokens.
- out_busy, output, 1, at least one token is in flight.
- out_rand_error, output, 1, sticky flag for a randomness underrun.

## Operation
- Token pipeline: a LATENCY-deep shift register of {valid, id[$clog2(NUM_REQ)-1:0]}. It shifts every cycle; there is no stall.
- Issue condition: any in_req_valid, and in_rand_valid is high, and in_flush is low.
  - The grant winner gets out_req_ready high.
  - out_inv_a equals in_req_data of the winner.
  - Stage 0 of the token register loads {1, winner id}.
- No issue:
  - out_req_ready is all zeros.
  - out_inv_a is driven to all-zero shares, so a stale masked value is never replayed.
  - Stage 0 loads {0, 0}.
- Response:
  - When stage LATENCY-1 holds a valid token, out_rsp_valid[id] is 1 and out_rsp_data equals in_inv_b.
  - Otherwise out_rsp_valid is 0 and out_rsp_data is 0.
  - Responses have no backpressure; requesters must accept them.
- In-flight counter:
  - Width is $clog2(LATENCY+1).
  - It increments on issue and decrements on a valid retire; it is unchanged when both happen in the same cycle.
  - It saturates at LATENCY, which is reachable only through back-to-back issue.
  - out_busy = (count != 0).
- out_rand_req = issue OR out_busy.
- out_rand_error is set when out_busy is high and in_rand_valid is low. It is cleared only by in_reset.
- Flush:
  - Clears every token valid bit and the counter at the next edge.
  - Suppresses issue in the flush cycle.
  - The inverter datapath is not reset; its outputs are ignored because no valid tokens remain.
- Reset values:
  - All token bits are 0 and the counter is 0.
  - The round-robin pointer is 0.
  - out_rand_error is 0.
  - All outputs are 0.
  - A reset mid-operation drops in-flight results with no response.

## Timing
- A request accepted at clock edge t has out_inv_a valid in the cycle before edge t. Its response is visible in the cycle after edge t+LATENCY-1, which is LATENCY cycles after issue.
- Throughput is one issue per cycle across all requesters.
- Grant is combinational from in_req_valid, in_rand_valid and the pointer. Requesters must not make in_req_valid depend on out_req_ready.
- A simultaneous issue and retire in the same cycle is legal; the counter holds its value.
- A flush in the same cycle as a retire suppresses that response.

## Configuration
- MASKED_SBOX_SCHED_RR_EN defined:
  - Round-robin arbitration.
  - The pointer advances to (winner+1) mod NUM_REQ after each issue.
  - The search starts at the pointer.
- MASKED_SBOX_SCHED_RR_EN undefined:
  - Fixed priority; the lowest index wins.
  - No pointer register exists.

## Test plan
- Single request: NUM_REQ=2, LATENCY=4, requester 1 issues shares {0x53^m, m}. Required: out_rsp_valid=2'b10 exactly 4 cycles later, with unmasked XOR of the response equal to 0xCA.
- Contention, RR enabled: both requesters hold valid for 6 cycles. Required: grants alternate 0,1,0,1,0,1 and responses return in the same order 4 cycles later. With RR disabled: six grants to requester 0 and none to requester 1.
- Randomness gate:
  - in_rand_valid=0 while requests are pending: no grant, out_rand_req=0.
  - in_rand_valid dropped for 1 cycle with tokens in flight: out_rand_error=1 and it stays 1.
- Flush: issue 3 back-to-back tokens, then assert in_flush 2 cycles later. Required: no out_rsp_valid, out_busy=0 the next cycle, and a new request afterwards completes normally.
- Async reset: assert in_reset between edges with 4 tokens in flight. Required: all outputs go to 0 immediately and no response follows.
- Back-to-back saturation: issue continuously for 20 cycles. Required: counter stays at 4, one response per cycle, and each result matches the golden inverse.
